// File: rtl/data_memory.sv
// Word-addressed data memory for the load/store stage.
// Synchronous write, combinational read, asynchronous active-low clear.
// Addr is a word index; any index at or beyond DEPTH is ignored on write
// and reads back as zero.
module data_memory #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] Write_data,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  output logic [DATA_WIDTH-1:0] ReadData
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      idx;
  logic                  in_range;
  logic                  wr_en;

  // DEPTH is a power of two, so an index is in range exactly when every
  // Addr bit above the index field is clear.
  assign idx      = Addr[IDX_W-1:0];
  assign in_range = (Addr[ADDR_WIDTH-1:IDX_W] == '0);
  assign wr_en    = MemWrite && in_range;

  // Storage: reset clears every word; otherwise one word per enabled write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (wr_en) begin
      mem[idx] <= Write_data;
    end
  end

  // Read port: zero unless reset is released, the strobe is up and the
  // index is in range. No write bypass: old data shows until the edge.
  always_comb begin
    ReadData = '0;
    if (rst && MemRead && in_range) ReadData = mem[idx];
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory. Expected read values are pushed to a
// scoreboard queue as stimulus is applied and popped 1 ns later to compare.
module tb_data_memory;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int DEPTH = 64;

  logic          clk;
  logic          rst;
  logic [AW-1:0] Addr;
  logic [DW-1:0] Write_data;
  logic          MemWrite;
  logic          MemRead;
  logic [DW-1:0] ReadData;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] model [DEPTH];

  data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .Addr       (Addr),
    .Write_data (Write_data),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .ReadData   (ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [DW-1:0] e;
    rst = 1'b0; Addr = '0; Write_data = '0; MemWrite = 1'b0; MemRead = 1'b1;
    #4;
    exp_q.push_back('0);
    e = exp_q.pop_front();
    checks++;
    if (ReadData !== e) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h", ReadData, e);
    end
    #5 rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      Addr = AW'(i);
      exp_q.push_back(model[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ReadData !== e) begin
        errors++;
        $display("FAIL reset_sweep addr=%0d got=%h exp=%h", i, ReadData, e);
      end
    end
  endtask

  task automatic test_write_sweep();
    logic [DW-1:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b1;
      Addr = AW'(i); Write_data = DW'(i);
      model[i] = DW'(i);
      exp_q.push_back('0);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ReadData !== e) begin
        errors++;
        $display("FAIL write_gated addr=%0d got=%h exp=%h", i, ReadData, e);
      end
    end
  endtask

  task automatic test_readback();
    logic [DW-1:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      MemWrite = 1'b0; MemRead = 1'b1;
      Addr = AW'(i);
      exp_q.push_back(model[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ReadData !== e) begin
        errors++;
        $display("FAIL readback addr=%0d got=%h exp=%h", i, ReadData, e);
      end
    end
  endtask

  task automatic test_gating_oob();
    logic [DW-1:0] e;
    // read strobe low
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0; Addr = AW'(5);
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (ReadData !== e) begin
      errors++;
      $display("FAIL read_gate got=%h exp=%h", ReadData, e);
    end
    // out-of-range write and read at index 64
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b1; Addr = AW'(64); Write_data = 64'hDEAD;
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (ReadData !== e) begin
      errors++;
      $display("FAIL oob_read got=%h exp=%h", ReadData, e);
    end
    @(posedge clk); #1;
    exp_q.push_back('0);
    e = exp_q.pop_front();
    checks++;
    if (ReadData !== e) begin
      errors++;
      $display("FAIL oob_read_after got=%h exp=%h", ReadData, e);
    end
    // high address bit set aliasing onto word 1 must also be dropped
    @(negedge clk);
    Addr = 64'h8000_0000_0000_0001; Write_data = 64'hBEEF;
    @(negedge clk);
    MemWrite = 1'b0;
    for (int i = 0; i < 2; i++) begin
      Addr = AW'(i);
      exp_q.push_back(model[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ReadData !== e) begin
        errors++;
        $display("FAIL oob_no_alias addr=%0d got=%h exp=%h", i, ReadData, e);
      end
    end
  endtask

  task automatic test_same_addr();
    logic [DW-1:0] e;
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b1; Addr = AW'(10); Write_data = '1;
    exp_q.push_back(model[10]);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (ReadData !== e) begin
      errors++;
      $display("FAIL rw_before got=%h exp=%h", ReadData, e);
    end
    model[10] = '1;
    @(posedge clk);
    exp_q.push_back(model[10]);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (ReadData !== e) begin
      errors++;
      $display("FAIL rw_after got=%h exp=%h", ReadData, e);
    end
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    int a [8];
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a[k] = 20 + 3 * k;
      MemRead = 1'b0; MemWrite = 1'b1;
      Addr = AW'(a[k]);
      Write_data = {$urandom(), $urandom()};
      model[a[k]] = Write_data;
    end
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(model[a[k]]);
    for (int k = 0; k < 8; k++) begin
      Addr = AW'(a[k]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ReadData !== e) begin
        errors++;
        $display("FAIL b2b addr=%0d got=%h exp=%h", a[k], ReadData, e);
      end
    end
    // neighbours untouched
    for (int k = 0; k < 7; k++) begin
      Addr = AW'(a[k] + 1);
      exp_q.push_back(model[a[k] + 1]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ReadData !== e) begin
        errors++;
        $display("FAIL b2b_neighbour addr=%0d got=%h exp=%h", a[k] + 1, ReadData, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e;
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; Addr = AW'(10);
    exp_q.push_back(model[10]);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (ReadData !== e) begin
      errors++;
      $display("FAIL pre_reset got=%h exp=%h", ReadData, e);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    exp_q.push_back('0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (ReadData !== e) begin
      errors++;
      $display("FAIL async_clear got=%h exp=%h", ReadData, e);
    end
    // write attempted while held in reset
    @(negedge clk);
    MemWrite = 1'b1; Addr = AW'(3); Write_data = 64'h1234;
    @(posedge clk); #1;
    exp_q.push_back('0);
    e = exp_q.pop_front();
    checks++;
    if (ReadData !== e) begin
      errors++;
      $display("FAIL write_in_reset got=%h exp=%h", ReadData, e);
    end
    @(negedge clk);
    MemWrite = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      Addr = AW'(i);
      exp_q.push_back(model[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ReadData !== e) begin
        errors++;
        $display("FAIL post_reset addr=%0d got=%h exp=%h", i, ReadData, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_sweep();
    test_readback();
    test_gating_oob();
    test_same_addr();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
